// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit barrel shifter under round-robin
// arbitration. The result is registered onto a single back-pressured response channel.
// Optional build macro SHIFT_ARB_STAT_EN adds saturating per-requester accept counters
// on the grant_cnt port. Without it, the port and the counter logic are absent.
module shift_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [2*DATA_W-1:0]   req_din,
   input  logic [9:0]            req_shamt,
   input  logic [3:0]            req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_dout,
   output logic                  rsp_id
`ifdef SHIFT_ARB_STAT_EN
   ,
   output logic [2*CNT_W-1:0]    grant_cnt
`endif
);

   localparam int SH_W = 5;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   localparam logic [1:0] OP_SRA = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SLL = 2'b10;

   genvar gi;

   logic [0:0]          state_reg, state_next;
   logic                last_grant_reg;
   logic [DATA_W-1:0]   rsp_dout_reg;
   logic                rsp_id_reg;

   logic [1:0]          grant;
   logic                slot_free;
   logic                accept;
   logic                sel;

   logic [DATA_W-1:0]   op_din;
   logic [SH_W-1:0]     op_sh;
   logic [1:0]          op_code;
   logic [2*DATA_W-1:0] rot_wide;
   logic [DATA_W-1:0]   shift_res;

   // Only DATA_W = 32 is meaningful (fixed 5-bit shift amounts). Other values
   // elaborate this empty marker block, so a misconfiguration is visible in the hierarchy.
   if (DATA_W != 32 || CNT_W < 1) begin : g_cfg_unsupported
   end

   // Round-robin: a lone requester always wins. On a tie, the side that did not win last time wins.
   for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = req_valid[gi] &
                         (~req_valid[1-gi] | (last_grant_reg != 1'(gi)));
   end

   assign rsp_valid = (state_reg == ST_FULL);
   assign slot_free = (state_reg == ST_EMPTY) | (rsp_valid & rsp_ready);
   assign req_ready = grant & {2{slot_free}};
   assign accept    = |(req_valid & req_ready);
   assign sel       = req_ready[1];
   assign rsp_dout  = rsp_dout_reg;
   assign rsp_id    = rsp_id_reg;

   // Shared barrel shifter working on the granted requester's payload
   always_comb begin
      op_din    = sel ? req_din[2*DATA_W-1:DATA_W] : req_din[DATA_W-1:0];
      op_sh     = sel ? req_shamt[2*SH_W-1:SH_W]   : req_shamt[SH_W-1:0];
      op_code   = sel ? req_op[3:2]                : req_op[1:0];
      rot_wide  = {op_din, op_din} >> op_sh;
      shift_res = rot_wide[DATA_W-1:0];
      case (op_code)
         OP_SRA:  shift_res = $unsigned($signed(op_din) >>> op_sh);
         OP_SRL:  shift_res = op_din >> op_sh;
         OP_SLL:  shift_res = op_din << op_sh;
         default: shift_res = rot_wide[DATA_W-1:0];
      endcase
   end

   // Next-state logic: a new accept always (re)fills the slot. A drain without refill empties it.
   always_comb begin
      state_next = state_reg;
      if (accept)
         state_next = ST_FULL;
      else if (rsp_valid & rsp_ready)
         state_next = ST_EMPTY;
   end

   // Response register, FSM state and arbitration priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_EMPTY;
         rsp_dout_reg   <= '0;
         rsp_id_reg     <= 1'b0;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rsp_dout_reg   <= shift_res;
            rsp_id_reg     <= sel;
            last_grant_reg <= sel;
         end
      end
   end

`ifdef SHIFT_ARB_STAT_EN
   for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Saturating count of operations accepted from this requester
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt_reg <= '0;
         else if (req_valid[gi] & req_ready[gi] & (cnt_reg != {CNT_W{1'b1}}))
            cnt_reg <= cnt_reg + 1'b1;
      end

      assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
   end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: table-driven directed vectors for shift_arbiter, plus
// hand-written sequences for asynchronous reset and (with SHIFT_ARB_STAT_EN) the counters.
module tb_shift_arbiter;

   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_din;
   logic [9:0]  req_shamt;
   logic [3:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dout;
   logic        rsp_id;
`ifdef SHIFT_ARB_STAT_EN
   logic [2*CNT_W-1:0] grant_cnt;
`endif

   int checks = 0;
   int errors = 0;

   shift_arbiter #(.DATA_W(32), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din   (req_din),
      .req_shamt (req_shamt),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dout  (rsp_dout),
      .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_STAT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] din0;
      logic [4:0]  sh0;
      logic [1:0]  op0;
      logic [31:0] din1;
      logic [4:0]  sh1;
      logic [1:0]  op1;
      logic        rdy;
      logic [1:0]  exp_ready;
      logic        exp_valid;
      logic [31:0] exp_dout;
      logic        exp_id;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] v,
                      input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
                      input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1,
                      input logic r, input logic [1:0] er, input logic ev,
                      input logic [31:0] ed, input logic ei);
      vec_t t;
      t.valid = v;   t.din0 = d0; t.sh0 = s0; t.op0 = o0;
      t.din1 = d1;   t.sh1 = s1;  t.op1 = o1; t.rdy = r;
      t.exp_ready = er; t.exp_valid = ev; t.exp_dout = ed; t.exp_id = ei;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic [1:0] v,
                        input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
                        input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1,
                        input logic r);
      req_valid = v;
      req_din   = {d1, d0};
      req_shamt = {s1, s0};
      req_op    = {o1, o0};
      rsp_ready = r;
   endtask

   initial begin
      // Ops: 00 SRA, 01 SRL, 10 SLL, 11 ROR. Expected results are after the edge.
      // Single requester: basic latency, then all ops on 0xFFFFFC00 >> 11
      add(2'b01, 32'h0000_0400, 5'd1,  2'b00, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'h0000_0200, 1'b0);
      add(2'b01, 32'hFFFF_FC00, 5'd11, 2'b00, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0);
      add(2'b10, 32'h0, 5'd0, 2'b00, 32'hFFFF_FC00, 5'd11, 2'b01, 1'b1, 2'b10, 1'b1, 32'h001F_FFFF, 1'b1);
      add(2'b01, 32'hFFFF_FC00, 5'd11, 2'b10, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'hFFE0_0000, 1'b0);
      add(2'b10, 32'h0, 5'd0, 2'b00, 32'hFFFF_FC00, 5'd11, 2'b11, 1'b1, 2'b10, 1'b1, 32'h801F_FFFF, 1'b1);
      // shamt = 0 passes the operand through for every op
      add(2'b01, 32'hFFFF_FC00, 5'd0, 2'b00, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'hFFFF_FC00, 1'b0);
      add(2'b10, 32'h0, 5'd0, 2'b00, 32'hFFFF_FC00, 5'd0, 2'b01, 1'b1, 2'b10, 1'b1, 32'hFFFF_FC00, 1'b1);
      add(2'b01, 32'hFFFF_FC00, 5'd0, 2'b10, 32'h0, 5'd0, 2'b00, 1'b1, 2'b01, 1'b1, 32'hFFFF_FC00, 1'b0);
      add(2'b10, 32'h0, 5'd0, 2'b00, 32'hFFFF_FC00, 5'd0, 2'b11, 1'b1, 2'b10, 1'b1, 32'hFFFF_FC00, 1'b1);
      // Both valid for 4 cycles: strict alternation starting with req0 (last winner was req1)
      for (int k = 0; k < 4; k++)
         add(2'b11, 32'h8000_0000, 5'd4, 2'b00, 32'h8000_0000, 5'd4, 2'b01, 1'b1,
             (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
             (k % 2 == 0) ? 32'hF800_0000 : 32'h0800_0000, (k % 2 == 0) ? 1'b0 : 1'b1);
      // Idle cycle drains the slot
      add(2'b00, 32'h0, 5'd0, 2'b00, 32'h0, 5'd0, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
      // EMPTY accepts even with rsp_ready low; then 3 stalled cycles hold the result
      add(2'b10, 32'h0, 5'd0, 2'b00, 32'h0000_0001, 5'd31, 2'b10, 1'b0, 2'b10, 1'b1, 32'h8000_0000, 1'b1);
      for (int k = 0; k < 3; k++)
         add(2'b11, 32'h8000_0000, 5'd4, 2'b00, 32'h1234_5678, 5'd8, 2'b11, 1'b0, 2'b00, 1'b1, 32'h8000_0000, 1'b1);
      // Consumer ready: the held result drains and the next op enters in the same cycle (req0, tie)
      add(2'b11, 32'h8000_0000, 5'd4, 2'b00, 32'h1234_5678, 5'd8, 2'b11, 1'b1, 2'b01, 1'b1, 32'hF800_0000, 1'b0);
      // Stalled req1 then wins the next tie: ROR 0x12345678 by 8
      add(2'b11, 32'h8000_0000, 5'd4, 2'b00, 32'h1234_5678, 5'd8, 2'b11, 1'b1, 2'b10, 1'b1, 32'h7812_3456, 1'b1);

      rst_n = 1'b0;
      drive(2'b00, 32'h0, 5'd0, 2'b00, 32'h0, 5'd0, 2'b00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("reset rsp_dout", rsp_dout, 32'h0);
      chk("reset rsp_id", {31'b0, rsp_id}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].din0, vecs[i].sh0, vecs[i].op0,
               vecs[i].din1, vecs[i].sh1, vecs[i].op1, vecs[i].rdy);
         @(negedge clk);
         chk($sformatf("vec%0d req_ready", i), {30'b0, req_ready}, {30'b0, vecs[i].exp_ready});
         @(posedge clk);
         #1;
         $display("vec %0d: valid=%b rdy=%b -> rsp_valid=%b dout=0x%08h id=%0d",
                  i, vecs[i].valid, vecs[i].rdy, rsp_valid, rsp_dout, rsp_id);
         chk($sformatf("vec%0d rsp_valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d rsp_dout", i), rsp_dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d rsp_id", i), {31'b0, rsp_id}, {31'b0, vecs[i].exp_id});
         end
      end

      // Asynchronous reset while FULL with both requesters valid
      drive(2'b11, 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_0F00, 5'd4, 2'b01, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: rsp_valid=%b dout=0x%08h id=%0d", rsp_valid, rsp_dout, rsp_id);
      chk("async rst rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("async rst rsp_dout", rsp_dout, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("post-rst tie req_ready", {30'b0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      $display("post-reset tie: rsp_valid=%b dout=0x%08h id=%0d", rsp_valid, rsp_dout, rsp_id);
      chk("post-rst rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("post-rst rsp_dout", rsp_dout, 32'h0000_000F);
      chk("post-rst rsp_id", {31'b0, rsp_id}, 32'h0);

`ifdef SHIFT_ARB_STAT_EN
      // Counters: fresh reset, then 20 accepts from req1 only
      rst_n = 1'b0;
      #2;
      chk("cnt reset", {24'b0, grant_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b10, 32'h0, 5'd0, 2'b00, 32'h0000_0001, 5'd1, 2'b10, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      $display("stat: grant_cnt=0x%02h after 20 req1 accepts", grant_cnt);
      chk("cnt saturate", {24'b0, grant_cnt}, 32'h0000_00F0);
      drive(2'b00, 32'h0, 5'd0, 2'b00, 32'h0, 5'd0, 2'b00, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
